// File: rtl/bp_fe_fetch_queue_pkg.sv
// Shared types for the FE fetch queue: exception codes, packet layout,
// queue state and the response-fault priority encoder.
package bp_fe_fetch_queue_pkg;

  localparam int vaddr_width_gp = 39;
  localparam int instr_width_gp = 32;

  typedef enum logic [2:0] {
    e_exc_none         = 3'd0,
    e_exc_access_fault = 3'd1,
    e_exc_page_fault   = 3'd2,
    e_exc_itlb_miss    = 3'd3,
    e_exc_icache_miss  = 3'd4
  } bp_fe_fetch_exc_e;

  typedef struct packed {
    logic [vaddr_width_gp-1:0] pc;
    logic [instr_width_gp-1:0] instr;
    bp_fe_fetch_exc_e          exc;
  } bp_fe_fetch_pkt_s;

  typedef enum logic {
    e_run  = 1'b0,
    e_halt = 1'b1
  } bp_fe_fetch_queue_state_e;

  // Most severe fault wins; a clean response maps to e_exc_none.
  function automatic bp_fe_fetch_exc_e fetch_exc_code(input logic access_fault,
                                                      input logic page_fault,
                                                      input logic itlb_miss,
                                                      input logic icache_miss);
    bp_fe_fetch_exc_e code;
    code = e_exc_none;
    if (access_fault)     code = e_exc_access_fault;
    else if (page_fault)  code = e_exc_page_fault;
    else if (itlb_miss)   code = e_exc_itlb_miss;
    else if (icache_miss) code = e_exc_icache_miss;
    return code;
  endfunction

endpackage

// File: rtl/bp_fe_fetch_queue_if.sv
// Fetch queue <-> bp_fe_mem link. Signal suffixes are from the fetch
// queue's point of view (master side).
//
// Handshake: a command transfers in any cycle where mem_cmd_v_o and
// mem_cmd_yumi_i are both high; yumi may only be raised while v is high.
// Its response comes back with mem_resp_v_i exactly two cycles later,
// unless mem_poison_o was high in the cycle after the transfer.
interface bp_fe_fetch_queue_if
  import bp_fe_fetch_queue_pkg::*;
#(
  parameter int vaddr_width_p = vaddr_width_gp,
  parameter int instr_width_p = instr_width_gp
);
  logic                     mem_cmd_v_o;
  logic [vaddr_width_p-1:0] mem_cmd_vaddr_o;
  logic                     mem_cmd_yumi_i;
  logic                     mem_poison_o;
  logic                     mem_resp_v_i;
  logic [instr_width_p-1:0] mem_resp_data_i;
  logic                     mem_resp_icache_miss_i;
  logic                     mem_resp_itlb_miss_i;
  logic                     mem_resp_page_fault_i;
  logic                     mem_resp_access_fault_i;

  modport master (
    output mem_cmd_v_o, mem_cmd_vaddr_o, mem_poison_o,
    input  mem_cmd_yumi_i, mem_resp_v_i, mem_resp_data_i,
           mem_resp_icache_miss_i, mem_resp_itlb_miss_i,
           mem_resp_page_fault_i, mem_resp_access_fault_i
  );

  modport slave (
    input  mem_cmd_v_o, mem_cmd_vaddr_o, mem_poison_o,
    output mem_cmd_yumi_i, mem_resp_v_i, mem_resp_data_i,
           mem_resp_icache_miss_i, mem_resp_itlb_miss_i,
           mem_resp_page_fault_i, mem_resp_access_fault_i
  );
endinterface

// File: rtl/bp_fe_fetch_queue_pkt_fifo.sv
// Circular packet FIFO with synchronous clear. Head is read straight from
// storage (no write-through), pointers wrap modulo els_p.
module bp_fe_fetch_pkt_fifo #(
  parameter  int width_p        = 8,
  parameter  int els_p          = 4,
  localparam int ptr_width_lp   = $clog2(els_p),
  localparam int count_width_lp = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      clear_i,
  input  logic                      v_i,
  input  logic [width_p-1:0]        data_i,
  input  logic                      yumi_i,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  output logic [count_width_lp-1:0] count_o
);

  logic [width_p-1:0]        mem_q [els_p];
  logic [ptr_width_lp-1:0]   rd_ptr_q, wr_ptr_q;
  logic [count_width_lp-1:0] count_q;
  logic                      pop;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop     = yumi_i & (count_q != '0);
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping; clear empties the buffer in one cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (v_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({v_i, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (v_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Upstream credit logic must never push into a full buffer without a pop.
  always @(posedge clk_i) begin
    if (!reset_i && !clear_i) assert (!(v_i && !pop && (count_q == count_width_lp'(els_p))));
  end

endmodule

// File: rtl/bp_fe_fetch_queue.sv
// FE fetch queue: issues fetches to bp_fe_mem only when a buffer slot is
// reserved for the response, tracks the fixed 2-cycle response pipe,
// and buffers in-order instruction/exception packets for decode.
module bp_fe_fetch_queue
  import bp_fe_fetch_queue_pkg::*;
#(
  parameter int vaddr_width_p = vaddr_width_gp,
  parameter int instr_width_p = instr_width_gp,
  parameter int fifo_els_p    = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     fetch_v_i,
  input  logic [vaddr_width_p-1:0] fetch_vaddr_i,
  output logic                     fetch_ready_o,
  bp_fe_fetch_queue_if.master      mem_if,
  input  logic                     flush_i,
  output logic                     pkt_v_o,
  output logic [vaddr_width_p-1:0] pkt_pc_o,
  output logic [instr_width_p-1:0] pkt_instr_o,
  output logic [2:0]               pkt_exc_o,
  input  logic                     pkt_yumi_i,
  output bp_fe_fetch_queue_state_e state_o
);

  localparam int pkt_width_lp   = vaddr_width_p + instr_width_p + 3;
  localparam int count_width_lp = $clog2(fifo_els_p + 1);

  bp_fe_fetch_queue_state_e  state_q;
  logic                      v_r_q, v_rr_q;
  logic [vaddr_width_p-1:0]  vaddr_r_q, vaddr_rr_q;
  logic [count_width_lp-1:0] count;
  logic [count_width_lp:0]   occupancy;
  logic                      cmd_accept, push, pop, fifo_v;
  bp_fe_fetch_exc_e          resp_exc;
  logic [instr_width_p-1:0]  resp_instr;
  logic [pkt_width_lp-1:0]   head;
  logic                      unused_resp_v;

  // v_rr_q is the authority for response arrival; the mem valid is redundant.
  assign unused_resp_v = mem_if.mem_resp_v_i;

  // Buffered plus in-flight entries; pops are ignored so the credit is conservative.
  assign occupancy = {1'b0, count}
                   + {{count_width_lp{1'b0}}, v_r_q}
                   + {{count_width_lp{1'b0}}, v_rr_q};

  assign fetch_ready_o = ~reset_i & (state_q == e_run) & ~flush_i
                       & (occupancy < (count_width_lp + 1)'(fifo_els_p));

  assign mem_if.mem_cmd_v_o     = fetch_v_i & fetch_ready_o;
  assign mem_if.mem_cmd_vaddr_o = fetch_vaddr_i;
  assign mem_if.mem_poison_o    = flush_i & ~reset_i;
  assign cmd_accept             = mem_if.mem_cmd_v_o & mem_if.mem_cmd_yumi_i;

  assign resp_exc   = fetch_exc_code(mem_if.mem_resp_access_fault_i,
                                     mem_if.mem_resp_page_fault_i,
                                     mem_if.mem_resp_itlb_miss_i,
                                     mem_if.mem_resp_icache_miss_i);
  assign resp_instr = (resp_exc == e_exc_none) ? mem_if.mem_resp_data_i : '0;

  // Responses landing in HALT belong to fetches younger than the fault.
  assign push = v_rr_q & (state_q == e_run) & ~flush_i;
  assign pop  = pkt_yumi_i & pkt_v_o & ~flush_i;

  // Response tracking valids; flush kills the stage whose response mem poisons.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r_q  <= 1'b0;
      v_rr_q <= 1'b0;
    end else begin
      v_r_q  <= cmd_accept;
      v_rr_q <= v_r_q & ~flush_i;
    end
  end

  // Address pipe paired with the valids above.
  always_ff @(posedge clk_i) begin
    vaddr_r_q  <= fetch_vaddr_i;
    vaddr_rr_q <= vaddr_r_q;
  end

  // RUN/HALT control: a faulting packet halts fetch until the next redirect.
  always_ff @(posedge clk_i) begin
    if (reset_i)                              state_q <= e_run;
    else if (flush_i)                         state_q <= e_run;
    else if (push && resp_exc != e_exc_none)  state_q <= e_halt;
  end

  assign state_o = state_q;

  bp_fe_fetch_pkt_fifo #(
    .width_p (pkt_width_lp),
    .els_p   (fifo_els_p)
  ) pkt_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (flush_i),
    .v_i     (push),
    .data_i  ({vaddr_rr_q, resp_instr, resp_exc}),
    .yumi_i  (pop),
    .v_o     (fifo_v),
    .data_o  (head),
    .count_o (count)
  );

  assign pkt_v_o     = fifo_v & ~reset_i;
  assign pkt_pc_o    = head[pkt_width_lp-1 -: vaddr_width_p];
  assign pkt_instr_o = head[3 +: instr_width_p];
  assign pkt_exc_o   = head[2:0];

endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// Directed bench for bp_fe_fetch_queue with a 2-cycle bp_fe_mem model.
module tb_bp_fe_fetch_queue;
  import bp_fe_fetch_queue_pkg::*;

  localparam int vw = 39;
  localparam int iw = 32;
  localparam int pw = vw + iw + 3;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                     fetch_v, flush, pkt_yumi, fetch_ready, pkt_v;
  logic [vw-1:0]            fetch_vaddr, pkt_pc;
  logic [iw-1:0]            pkt_instr;
  logic [2:0]               pkt_exc;
  bp_fe_fetch_queue_state_e state;

  bp_fe_fetch_queue_if #(.vaddr_width_p(vw), .instr_width_p(iw)) mem_if ();

  bp_fe_fetch_queue #(.vaddr_width_p(vw), .instr_width_p(iw), .fifo_els_p(4)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .fetch_v_i     (fetch_v),
    .fetch_vaddr_i (fetch_vaddr),
    .fetch_ready_o (fetch_ready),
    .mem_if        (mem_if),
    .flush_i       (flush),
    .pkt_v_o       (pkt_v),
    .pkt_pc_o      (pkt_pc),
    .pkt_instr_o   (pkt_instr),
    .pkt_exc_o     (pkt_exc),
    .pkt_yumi_i    (pkt_yumi),
    .state_o       (state)
  );

  // bp_fe_mem model: accepts every command, answers 2 cycles later unless poisoned.
  // Its own reset is separate so responses in flight can outlive a DUT reset.
  logic          mem_rst;
  logic          s1_v, s2_v;
  logic [vw-1:0] s1_a, s2_a;
  logic [3:0]    s1_f, s2_f, cur_faults;  // {access, page, itlb, icache}

  function automatic logic [iw-1:0] data_fn(input logic [vw-1:0] a);
    return a[31:0] ^ 32'h1357_9bdf;
  endfunction

  assign mem_if.mem_cmd_yumi_i = mem_if.mem_cmd_v_o;

  always_ff @(posedge clk) begin
    if (mem_rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= mem_if.mem_cmd_v_o & mem_if.mem_cmd_yumi_i;
      s2_v <= s1_v & ~mem_if.mem_poison_o;
    end
    s1_a <= mem_if.mem_cmd_vaddr_o;
    s2_a <= s1_a;
    s1_f <= cur_faults;
    s2_f <= s1_f;
  end

  assign mem_if.mem_resp_v_i            = s2_v;
  assign mem_if.mem_resp_data_i         = s2_v ? data_fn(s2_a) : '0;
  assign mem_if.mem_resp_access_fault_i = s2_v & s2_f[3];
  assign mem_if.mem_resp_page_fault_i   = s2_v & s2_f[2];
  assign mem_if.mem_resp_itlb_miss_i    = s2_v & s2_f[1];
  assign mem_if.mem_resp_icache_miss_i  = s2_v & s2_f[0];

  // scoreboard
  logic [pw-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [vw-1:0] next_addr;
  logic          rdy_seen;
  logic          rdy_exp [7];

  function automatic logic [pw-1:0] mk_pkt(input logic [vw-1:0] a, input logic [3:0] f);
    bp_fe_fetch_pkt_s p;
    p.pc = a;
    if (f[3])      p.exc = e_exc_access_fault;
    else if (f[2]) p.exc = e_exc_page_fault;
    else if (f[1]) p.exc = e_exc_itlb_miss;
    else if (f[0]) p.exc = e_exc_icache_miss;
    else           p.exc = e_exc_none;
    p.instr = (p.exc == e_exc_none) ? data_fn(a) : '0;
    return p;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: one clock of fetch/pop activity; pops are compared against the queue
  task automatic cycle(input logic fv, input logic pop_en, input logic [3:0] faults,
                       input logic exp_en);
    fetch_v     = fv;
    fetch_vaddr = next_addr;
    cur_faults  = faults;
    pkt_yumi    = pop_en & pkt_v;
    #1;
    rdy_seen = fetch_ready;
    if (pkt_yumi) begin
      if (exp_q.size() == 0) check_eq("unexpected_pkt", pkt_pc, '1);
      else                   check_eq("pkt", {pkt_pc, pkt_instr, pkt_exc}, exp_q.pop_front());
    end
    if (mem_if.mem_cmd_v_o && mem_if.mem_cmd_yumi_i) begin
      if (exp_en) exp_q.push_back(mk_pkt(next_addr, faults));
      next_addr = next_addr + 4;
    end
    @(posedge clk);
    #1;
    fetch_v    = 1'b0;
    pkt_yumi   = 1'b0;
    cur_faults = '0;
    #1;
  endtask

  task automatic do_flush(input logic fv);
    flush       = 1'b1;
    fetch_v     = fv;
    fetch_vaddr = next_addr;
    #1;
    check_eq("flush_poison", mem_if.mem_poison_o, 1);
    check_eq("flush_no_cmd", mem_if.mem_cmd_v_o, 0);
    check_eq("flush_ready", fetch_ready, 0);
    @(posedge clk);
    #1;
    flush   = 1'b0;
    fetch_v = 1'b0;
    #1;
    check_eq("flush_pkt_v", pkt_v, 0);
    check_eq("flush_state", state, e_run);
    check_eq("flush_ready_after", fetch_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_rst = 1'b1; flush = 1'b0; pkt_yumi = 1'b0;
    fetch_v = 1'b1; fetch_vaddr = '0; cur_faults = '0; next_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pkt_v", pkt_v, 0);
    check_eq("rst_ready", fetch_ready, 0);
    check_eq("rst_cmd_v", mem_if.mem_cmd_v_o, 0);
    check_eq("rst_poison", mem_if.mem_poison_o, 0);
    reset = 1'b0; mem_rst = 1'b0; fetch_v = 1'b0;
    #1;
    check_eq("post_rst_state", state, e_run);
    check_eq("post_rst_ready", fetch_ready, 1);

    // back-to-back fetches, no pops: credit closes at 4 buffered+in-flight
    rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    next_addr = 39'h0_8000_0000;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b0, 4'b0000, 1'b1);
      check_eq("fill_ready", rdy_seen, rdy_exp[i]);
    end
    check_eq("fill_queued", exp_q.size(), 4);
    cycle(1'b0, 1'b1, 4'b0000, 1'b0);
    check_eq("pop_cycle_ready", rdy_seen, 0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    check_eq("after_pop_ready", rdy_seen, 1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'b0000, 1'b0);
    check_eq("fill_drained", exp_q.size(), 0);
    check_eq("fill_empty", pkt_v, 0);

    // streaming with pops every cycle from a full buffer, across pointer wraps
    next_addr = 39'h0_8000_0040;
    for (int i = 0; i < 6; i++)  cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 8; i++)  cycle(1'b0, 1'b1, 4'b0000, 1'b0);
    check_eq("stream_drained", exp_q.size(), 0);
    check_eq("stream_empty", pkt_v, 0);

    // icache miss halts; the younger fetch's response is dropped
    next_addr = 39'h0_8000_0010;
    cycle(1'b1, 1'b0, 4'b0001, 1'b1);
    cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    check_eq("halt_state", state, e_halt);
    check_eq("halt_ready", fetch_ready, 0);
    check_eq("halt_pkt_v", pkt_v, 1);
    cycle(1'b1, 1'b1, 4'b0000, 1'b0);
    check_eq("halt_ready_pop", rdy_seen, 0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    check_eq("halt_young_dropped", pkt_v, 0);
    check_eq("halt_still", state, e_halt);
    check_eq("halt_ready_late", fetch_ready, 0);
    do_flush(1'b0);

    // fault priority: access+itlb -> access, page+icache -> page
    next_addr = 39'h0_8000_0100;
    cycle(1'b1, 1'b0, 4'b1010, 1'b1);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 1'b1, 4'b0000, 1'b0);
    check_eq("prio_halt", state, e_halt);
    do_flush(1'b0);
    next_addr = 39'h0_8000_0180;
    cycle(1'b1, 1'b0, 4'b0101, 1'b1);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 1'b1, 4'b0000, 1'b0);
    do_flush(1'b0);

    // flush with 2 buffered and v_r/v_rr both busy
    next_addr = 39'h0_8000_0200;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    check_eq("preflush_pkt_v", pkt_v, 1);
    do_flush(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'b0000, 1'b0);
    check_eq("flush_no_late_pkt", pkt_v, 0);
    next_addr = 39'h0_8000_0300;
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    check_eq("lat_not_yet", pkt_v, 0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    check_eq("lat_arrived", pkt_v, 1);
    cycle(1'b0, 1'b1, 4'b0000, 1'b0);

    // reset mid-operation with entries buffered and in flight
    next_addr = 39'h0_8000_0400;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    reset = 1'b1; fetch_v = 1'b1; fetch_vaddr = next_addr;
    #1;
    check_eq("mid_rst_ready", fetch_ready, 0);
    check_eq("mid_rst_cmd_v", mem_if.mem_cmd_v_o, 0);
    check_eq("mid_rst_pkt_v", pkt_v, 0);
    @(posedge clk);
    #1;
    reset = 1'b0; fetch_v = 1'b0;
    #1;
    check_eq("after_rst_pkt_v", pkt_v, 0);
    check_eq("after_rst_ready", fetch_ready, 1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 4'b0000, 1'b0);
    check_eq("late_resp_ignored", pkt_v, 0);
    next_addr = 39'h0_8000_0500;
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 1'b1, 4'b0000, 1'b0);
    check_eq("final_drained", exp_q.size(), 0);
    check_eq("final_empty", pkt_v, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
